// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the SDRAM/system PLL reset sequencer.
// The optional loss counter is controlled by PLL_SEQ_LOSS_COUNTER_EN in the top level.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRST      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_seq_state_t;

  localparam int LOSS_CNT_W = 8;

  // Width of the shared down-counter; it only ever holds (cycles - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_pll_reset_sequencer_if.sv
// Bundle of PLL-side and reset-tree signals of the PLL reset sequencer.
// The sequencer is the master; the PLL wrapper / reset tree side is the slave.
interface sdram_pll_reset_sequencer_if #(
  parameter int RETRY_W = 2
);
  import pll_seq_pkg::*;

  logic                  pll_locked;
  logic                  fault_clr;
  logic                  pll_rst;
  logic                  sys_rst;
  logic                  sys_ready;
  logic                  fault;
  logic [RETRY_W-1:0]    retry_cnt;
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss_cnt;

  modport master (
    input  pll_locked, fault_clr,
    output pll_rst, sys_rst, sys_ready, fault, retry_cnt, lock_lost, loss_cnt
  );

  modport slave (
    output pll_locked, fault_clr,
    input  pll_rst, sys_rst, sys_ready, fault, retry_cnt, lock_lost, loss_cnt
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
// Cleared asynchronously so a reset never leaves a stale "locked" behind.
module pll_lock_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [1:0] sync_r;

  // synchronizer shift chain
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], d};
    end
  end

  assign q = sync_r[1];

endmodule

// File: rtl/sdram_pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer holding the system in reset until lock is stable.
// Define PLL_SEQ_LOSS_COUNTER_EN to implement the saturating loss-of-lock counter.
module sdram_pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 10,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                        refclk,
  input  logic                        rst,
  sdram_pll_reset_sequencer_if.master bus
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int CNT_W   = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  // The WAIT_LOCK cycle that first sees lk counts as the first qualified cycle.
  localparam bit               SKIP_QUALIFY = (LOCK_STABLE_CYCLES == 1);
  localparam logic [CNT_W-1:0] PRST_LOAD    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUAL_LOAD    = CNT_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ZERO = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  pll_seq_state_t     state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [RETRY_W-1:0] retry_cnt_r, retry_nxt_s;
  logic               loss_event_s;
  logic               lk_s;
  logic               pll_rst_r, sys_rst_r, sys_ready_r, fault_r, lock_lost_r;

  pll_lock_sync u_lock_sync (
    .clk (refclk),
    .clr (rst),
    .d   (bus.pll_locked),
    .q   (lk_s)
  );

  // next-state, shared counter and retry bookkeeping
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    retry_nxt_s  = retry_cnt_r;
    loss_event_s = 1'b0;
    case (state_r)
      ST_PRST: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          if (SKIP_QUALIFY) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = RETRY_ZERO;
          end else begin
            state_nxt_s = ST_QUALIFY;
            cnt_nxt_s   = QUAL_LOAD;
          end
        end else if (cnt_r == CNT_ZERO) begin
          retry_nxt_s = retry_cnt_r + RETRY_ONE;
          if ((retry_cnt_r + RETRY_ONE) == RETRY_MAX) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_PRST;
            cnt_nxt_s   = PRST_LOAD;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_QUALIFY: begin
        if (!lk_s) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = WAIT_LOAD;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RUN;
          retry_nxt_s = RETRY_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_nxt_s  = ST_PRST;
          cnt_nxt_s    = PRST_LOAD;
          loss_event_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_nxt_s = ST_PRST;
          cnt_nxt_s   = PRST_LOAD;
          retry_nxt_s = RETRY_ZERO;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s = ST_PRST;
        cnt_nxt_s   = PRST_LOAD;
      end
    endcase
  end

  // state, counters and registered output decodes (outputs trail state by one edge)
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_PRST;
      cnt_r       <= PRST_LOAD;
      retry_cnt_r <= RETRY_ZERO;
      lock_lost_r <= 1'b0;
      pll_rst_r   <= 1'b1;
      sys_rst_r   <= 1'b1;
      sys_ready_r <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      lock_lost_r <= lock_lost_r | loss_event_s;
      pll_rst_r   <= (state_r == ST_PRST) || (state_r == ST_FAULT);
      sys_rst_r   <= (state_r != ST_RUN);
      sys_ready_r <= (state_r == ST_RUN);
      fault_r     <= (state_r == ST_FAULT);
    end
  end

`ifdef PLL_SEQ_LOSS_COUNTER_EN
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = {LOSS_CNT_W{1'b1}};
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);
  logic [LOSS_CNT_W-1:0] loss_cnt_r;

  // saturating loss-of-lock counter
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt_r <= {LOSS_CNT_W{1'b0}};
    end else if (loss_event_s && (loss_cnt_r != LOSS_MAX)) begin
      loss_cnt_r <= loss_cnt_r + LOSS_ONE;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign bus.loss_cnt = loss_cnt_r;
`else
  assign bus.loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

  assign bus.pll_rst   = pll_rst_r;
  assign bus.sys_rst   = sys_rst_r;
  assign bus.sys_ready = sys_ready_r;
  assign bus.fault     = fault_r;
  assign bus.retry_cnt = retry_cnt_r;
  assign bus.lock_lost = lock_lost_r;

endmodule

// File: tb/tb_sdram_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer: RST_PULSE=4, LOCK_STABLE=8, TIMEOUT=32, MAX_RETRIES=2.
// Expected cycle numbers are counted in refclk edges after the stimulus change.
module tb_sdram_pll_reset_sequencer;
  import pll_seq_pkg::*;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int TO = 32;
  localparam int MR = 2;
`ifdef PLL_SEQ_LOSS_COUNTER_EN
  localparam logic [7:0] LOSS_EXP1 = 8'd1;
`else
  localparam logic [7:0] LOSS_EXP1 = 8'd0;
`endif

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sdram_pll_reset_sequencer_if #(.RETRY_W(2)) bus ();

  sdram_pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // k = tick index at which sys_ready is first seen high, -1 if budget expires
  task automatic wait_ready(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget && k < 0; i++) begin
      tick();
      if (bus.sys_ready === 1'b1) k = i;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.fault_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.fault_clr  = 1'b0;
    tick();
    tick();
    checks += 7;
    if (bus.pll_rst !== 1'b1)   begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst !== 1'b1)   begin failures++; $display("FAIL reset_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.sys_ready !== 1'b0) begin failures++; $display("FAIL reset_sys_ready got=%b exp=0", bus.sys_ready); end
    if (bus.fault !== 1'b0)     begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
    if (bus.retry_cnt !== 2'd0) begin failures++; $display("FAIL reset_retry got=%0d exp=0", bus.retry_cnt); end
    if (bus.lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost got=%b exp=0", bus.lock_lost); end
    if (bus.loss_cnt !== 8'd0)  begin failures++; $display("FAIL reset_loss_cnt got=%0d exp=0", bus.loss_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int hi;
    int k;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pll_rst === 1'b1) hi++;
    end
    checks++;
    if (hi != RP) begin failures++; $display("FAIL nominal_pulse_len got=%0d exp=%0d", hi, RP); end
    bus.pll_locked = 1'b1;
    wait_ready(40, k);
    checks += 4;
    if (k != 11)                begin failures++; $display("FAIL nominal_ready_latency got=%0d exp=11", k); end
    if (bus.sys_rst !== 1'b0)   begin failures++; $display("FAIL nominal_sys_rst got=%b exp=0", bus.sys_rst); end
    if (bus.retry_cnt !== 2'd0) begin failures++; $display("FAIL nominal_retry got=%0d exp=0", bus.retry_cnt); end
    if (bus.pll_rst !== 1'b0)   begin failures++; $display("FAIL nominal_pll_rst got=%b exp=0", bus.pll_rst); end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.sys_ready !== 1'b1) begin failures++; $display("FAIL run_fault_clr_ignored got=%b exp=1", bus.sys_ready); end
  endtask

  task automatic test_run_loss();
    int k;
    bus.pll_locked = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        checks++;
        if (bus.sys_rst !== 1'b0) begin failures++; $display("FAIL loss_early_sys_rst got=%b exp=0", bus.sys_rst); end
      end
    end
    checks += 5;
    if (bus.sys_rst !== 1'b1)     begin failures++; $display("FAIL loss_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.pll_rst !== 1'b1)     begin failures++; $display("FAIL loss_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_ready !== 1'b0)   begin failures++; $display("FAIL loss_sys_ready got=%b exp=0", bus.sys_ready); end
    if (bus.lock_lost !== 1'b1)   begin failures++; $display("FAIL loss_lock_lost got=%b exp=1", bus.lock_lost); end
    if (bus.loss_cnt !== LOSS_EXP1) begin failures++; $display("FAIL loss_cnt got=%0d exp=%0d", bus.loss_cnt, LOSS_EXP1); end
    bus.pll_locked = 1'b1;
    wait_ready(60, k);
    checks += 3;
    if (k != 12)                  begin failures++; $display("FAIL relock_latency got=%0d exp=12", k); end
    if (bus.lock_lost !== 1'b1)   begin failures++; $display("FAIL relock_lock_lost got=%b exp=1", bus.lock_lost); end
    if (bus.loss_cnt !== LOSS_EXP1) begin failures++; $display("FAIL relock_loss_cnt got=%0d exp=%0d", bus.loss_cnt, LOSS_EXP1); end
  endtask

  task automatic test_async_reset_run();
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.sys_rst !== 1'b1)   begin failures++; $display("FAIL async_run_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.pll_rst !== 1'b1)   begin failures++; $display("FAIL async_run_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_ready !== 1'b0) begin failures++; $display("FAIL async_run_sys_ready got=%b exp=0", bus.sys_ready); end
    if (bus.lock_lost !== 1'b0) begin failures++; $display("FAIL async_run_lock_lost got=%b exp=0", bus.lock_lost); end
    tick();
  endtask

  task automatic test_qualify_glitch();
    int first;
    int pr;
    apply_reset();
    repeat (10) tick();
    bus.pll_locked = 1'b1;
    first = -1;
    pr = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 7) bus.pll_locked = 1'b0;
      if (k == 8) bus.pll_locked = 1'b1;
      if (bus.pll_rst === 1'b1) pr++;
      if (first < 0 && bus.sys_ready === 1'b1) first = k;
    end
    checks += 3;
    if (first != 19)            begin failures++; $display("FAIL glitch_ready_latency got=%0d exp=19", first); end
    if (pr != 0)                begin failures++; $display("FAIL glitch_pll_rst_cycles got=%0d exp=0", pr); end
    if (bus.retry_cnt !== 2'd0) begin failures++; $display("FAIL glitch_retry got=%0d exp=0", bus.retry_cnt); end
  endtask

  task automatic test_async_reset_qualify();
    int hi;
    apply_reset();
    bus.pll_locked = 1'b1;
    repeat (7) tick();
    checks += 2;
    if (bus.pll_rst !== 1'b0)   begin failures++; $display("FAIL qual_pre_pll_rst got=%b exp=0", bus.pll_rst); end
    if (bus.sys_ready !== 1'b0) begin failures++; $display("FAIL qual_pre_sys_ready got=%b exp=0", bus.sys_ready); end
    #3;
    rst = 1'b1;
    #1;
    checks += 5;
    if (bus.pll_rst !== 1'b1)   begin failures++; $display("FAIL async_qual_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst !== 1'b1)   begin failures++; $display("FAIL async_qual_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.sys_ready !== 1'b0) begin failures++; $display("FAIL async_qual_sys_ready got=%b exp=0", bus.sys_ready); end
    if (bus.fault !== 1'b0)     begin failures++; $display("FAIL async_qual_fault got=%b exp=0", bus.fault); end
    if (bus.retry_cnt !== 2'd0) begin failures++; $display("FAIL async_qual_retry got=%0d exp=0", bus.retry_cnt); end
    tick();
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pll_rst === 1'b1) hi++;
    end
    checks++;
    if (hi != RP) begin failures++; $display("FAIL abort_pulse_len got=%0d exp=%0d", hi, RP); end
  endtask

  task automatic test_timeout_fault();
    logic exp_pr;
    apply_reset();
    for (int k = 1; k <= 80; k++) begin
      tick();
      exp_pr = (k <= 4) || (k >= 37 && k <= 40) || (k >= 73);
      checks++;
      if (bus.pll_rst !== exp_pr) begin failures++; $display("FAIL timeout_pll_rst k=%0d got=%b exp=%b", k, bus.pll_rst, exp_pr); end
      if (k == 36) begin
        checks++;
        if (bus.retry_cnt !== 2'd1) begin failures++; $display("FAIL timeout_retry1 got=%0d exp=1", bus.retry_cnt); end
      end
      if (k == 72) begin
        checks += 2;
        if (bus.retry_cnt !== 2'd2) begin failures++; $display("FAIL timeout_retry2 got=%0d exp=2", bus.retry_cnt); end
        if (bus.fault !== 1'b0)     begin failures++; $display("FAIL timeout_fault_early got=%b exp=0", bus.fault); end
      end
      if (k == 73) begin
        checks++;
        if (bus.fault !== 1'b1) begin failures++; $display("FAIL timeout_fault got=%b exp=1", bus.fault); end
      end
    end
    repeat (5) tick();
    checks += 3;
    if (bus.fault !== 1'b1)     begin failures++; $display("FAIL fault_hold got=%b exp=1", bus.fault); end
    if (bus.sys_rst !== 1'b1)   begin failures++; $display("FAIL fault_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.retry_cnt !== 2'd2) begin failures++; $display("FAIL fault_retry_sat got=%0d exp=2", bus.retry_cnt); end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    checks++;
    if (bus.retry_cnt !== 2'd0) begin failures++; $display("FAIL clr_retry got=%0d exp=0", bus.retry_cnt); end
    tick();
    checks += 2;
    if (bus.fault !== 1'b0)   begin failures++; $display("FAIL clr_fault got=%b exp=0", bus.fault); end
    if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL clr_pll_rst got=%b exp=1", bus.pll_rst); end
    repeat (3) tick();
    checks++;
    if (bus.pll_rst !== 1'b1) begin failures++; $display("FAIL clr_pulse_end got=%b exp=1", bus.pll_rst); end
    tick();
    checks++;
    if (bus.pll_rst !== 1'b0) begin failures++; $display("FAIL clr_wait_lock got=%b exp=0", bus.pll_rst); end
  endtask

`ifdef PLL_SEQ_LOSS_COUNTER_EN
  task automatic test_saturation();
    int k;
    apply_reset();
    bus.pll_locked = 1'b1;
    wait_ready(60, k);
    for (int n = 0; n < 300; n++) begin
      bus.pll_locked = 1'b0;
      repeat (4) tick();
      bus.pll_locked = 1'b1;
      wait_ready(60, k);
      checks++;
      if (k < 0) begin failures++; $display("FAIL sat_relock_timeout n=%0d got=%0d exp>0", n, k); end
    end
    checks++;
    if (bus.loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_loss_cnt got=%0d exp=255", bus.loss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_run_loss();
    test_async_reset_run();
    test_qualify_glitch();
    test_async_reset_qualify();
    test_timeout_fault();
`ifdef PLL_SEQ_LOSS_COUNTER_EN
    test_saturation();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
